cordic_seq: RTL

Iterative, one-micro-rotation-per-clock CORDIC sequencer that computes sin and cos of an unsigned Q1.31 angle using the 8-entry arctangent table and the 8-iteration gain constant. It owns the start/busy/done handshake, the iteration counter and the x/y/z working registers, and feeds the trig datapath in place of the combinational table-only CORDIC wrapper. One result takes 8 clocks; results are held until the next completion.

---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_seq_if.sv | 30 +++
 rtl/cordic_stage.sv | 38 +++
 rtl/cordic_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// ============================================================================
// cordic_pkg : shared CORDIC constants (arctan table, gain, pi/2) and FSM type
// Rev 1.0
// ============================================================================
`default_nettype none

package cordic_pkg;

   localparam int CORDIC_W  = 32;
   localparam int CORDIC_WX = CORDIC_W + 2;
   localparam int TAB_DEPTH = 8;

   localparam logic [CORDIC_W-1:0] C_GAIN_K  = 32'h4DBA_AAA5;
   localparam logic [CORDIC_W-1:0] C_HALF_PI = 32'hC90F_DAA2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // atan(2^-i) scaled by 2^31
   function automatic logic [CORDIC_W-1:0] theta_lut(input logic [2:0] idx);
      logic [CORDIC_W-1:0] v;
      case (idx)
         3'd0:    v = 32'h6487_ED51;
         3'd1:    v = 32'h3B58_CE0A;
         3'd2:    v = 32'h1F5B_75F8;
         3'd3:    v = 32'h0FEA_DD4C;
         3'd4:    v = 32'h07FD_56EC;
         3'd5:    v = 32'h03FF_AAB6;
         3'd6:    v = 32'h01FF_F554;
         default: v = 32'h00FF_FEAA;
      endcase
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_seq_if.sv
// ============================================================================
// cordic_seq_if : start/busy/done handshake and data bus of the CORDIC sequencer
// Optional abort signal present with CORDIC_SEQ_ABORT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

interface cordic_seq_if #(
   parameter int W = 32
);
   logic         start;
   logic [W-1:0] rad;
`ifdef CORDIC_SEQ_ABORT_EN
   logic         abort;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sin_o;
   logic [W-1:0] cos_o;

`ifdef CORDIC_SEQ_ABORT_EN
   modport master (output start, rad, abort, input busy, done, sin_o, cos_o);
   modport slave  (input start, rad, abort, output busy, done, sin_o, cos_o);
`else
   modport master (output start, rad, input busy, done, sin_o, cos_o);
   modport slave  (input start, rad, output busy, done, sin_o, cos_o);
`endif

endinterface

`default_nettype wire

// File: rtl/cordic_stage.sv
// ============================================================================
// cordic_stage : one combinational CORDIC micro-rotation (rotation mode)
// Rev 1.0
// ============================================================================
`default_nettype none

module cordic_stage
   import cordic_pkg::*;
#(
   parameter int W = CORDIC_W
) (
   input  logic signed [W+1:0] i_x,
   input  logic signed [W+1:0] i_y,
   input  logic signed [W+1:0] i_z,
   input  logic        [2:0]   i_shift,
   input  logic        [W-1:0] i_theta,
   output logic signed [W+1:0] o_x,
   output logic signed [W+1:0] o_y,
   output logic signed [W+1:0] o_z
);

   logic               w_pos;
   logic signed [W+1:0] w_xs;
   logic signed [W+1:0] w_ys;
   logic signed [W+1:0] w_th;

   assign w_pos = ~i_z[W+1];
   assign w_xs  = i_x >>> i_shift;
   assign w_ys  = i_y >>> i_shift;
   assign w_th  = signed'({2'b00, i_theta});

   assign o_x = w_pos ? (i_x - w_ys) : (i_x + w_ys);
   assign o_y = w_pos ? (i_y + w_xs) : (i_y - w_xs);
   assign o_z = w_pos ? (i_z - w_th) : (i_z + w_th);

endmodule

`default_nettype wire

// File: rtl/cordic_seq.sv
// ============================================================================
// cordic_seq : iterative sin/cos CORDIC, one micro-rotation per clock.
// Optional CORDIC_SEQ_ABORT_EN adds an abort input.   Rev 1.0
// ============================================================================
`default_nettype none

module cordic_seq
   import cordic_pkg::*;
#(
   parameter int ITER = 8,
   parameter int W    = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   cordic_seq_if.slave  bus
);

   localparam int WX = W + 2;
   localparam logic [2:0] C_LAST = 3'(ITER - 1);

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_iter;
   logic signed [WX-1:0] r_x;
   logic signed [WX-1:0] r_y;
   logic signed [WX-1:0] r_z;
   logic signed [WX-1:0] w_x_nx;
   logic signed [WX-1:0] w_y_nx;
   logic signed [WX-1:0] w_z_nx;
   logic [W-1:0]        r_sin;
   logic [W-1:0]        r_cos;
   logic [W-1:0]        w_rad_sat;
   logic                w_last;
   logic                w_abort;
   logic                w_load;
   logic                w_step;
   logic                w_capture;
   logic                w_busy;
   logic                w_done;

`ifdef CORDIC_SEQ_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_last    = (r_iter == C_LAST);
   assign w_rad_sat = (bus.rad > W'(C_HALF_PI)) ? W'(C_HALF_PI) : bus.rad;

   // Negative results clamp to zero, anything at or above 2.0 saturates.
   function automatic logic [W-1:0] clamp_out(input logic signed [WX-1:0] v);
      if (v[WX-1])
         return '0;
      else if (v[WX-2])
         return '1;
      else
         return v[W-1:0];
   endfunction

   cordic_stage #(.W(W)) u_stage (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_z     (r_z),
      .i_shift (r_iter),
      .i_theta (W'(theta_lut(r_iter))),
      .o_x     (w_x_nx),
      .o_y     (w_y_nx),
      .o_z     (w_z_nx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.start) w_next = ST_RUN;
         ST_RUN: begin
            if (w_abort)
               w_next = ST_IDLE;
            else if (w_last)
               w_next = ST_DONE;
         end
         ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load    = 1'b0;
      w_step    = 1'b0;
      w_capture = 1'b0;
      w_busy    = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         ST_IDLE: w_load = bus.start;
         ST_RUN: begin
            w_busy    = 1'b1;
            w_step    = ~w_abort;
            w_capture = w_last & ~w_abort;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_load = bus.start;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_iter <= '0;
      end else if (w_load) begin
         r_x    <= signed'({2'b00, W'(C_GAIN_K)});
         r_y    <= '0;
         r_z    <= signed'({2'b00, w_rad_sat});
         r_iter <= '0;
      end else if (w_step) begin
         r_x    <= w_x_nx;
         r_y    <= w_y_nx;
         r_z    <= w_z_nx;
         r_iter <= r_iter + 3'd1;
      end
   end

   // Results come straight from the final rotation so all ITER steps count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sin <= '0;
         r_cos <= '0;
      end else if (w_capture) begin
         r_sin <= clamp_out(w_y_nx);
         r_cos <= clamp_out(w_x_nx);
      end
   end

   assign bus.busy  = w_busy;
   assign bus.done  = w_done;
   assign bus.sin_o = r_sin;
   assign bus.cos_o = r_cos;

endmodule

`default_nettype wire
